// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types and the coherence controller state encoding.
package cpu_types_pkg;

    localparam int CPU_MAX = 8;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

    typedef enum logic [2:0] {IDLE, SNOOP, MEMRD, MEMWR, C2C, IFETCH} cc_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        // Offset i from ptr is the priority rank; j is the physical requester.
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!any && (j == ((int'(ptr) + i) % N)) && req[j]) begin
                    any    = 1'b1;
                    gnt[j] = 1'b1;
                    idx    = IW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/cc_arbiter.sv
// Coherence controller: arbitrates icache/dcache traffic onto one memory port with snooping.
//
// state  | meaning
// IDLE   | arbitrate; dcache requests beat icache requests
// SNOOP  | one cycle broadcasting the winner's address to all other dcaches
// MEMRD  | dcache fill from memory
// MEMWR  | eviction writeback to memory
// C2C    | snooper supplies data to requester while writing it back to memory
// IFETCH | icache fill from memory
module cc_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [CPUS-1:0]   iREN,
    input  word_t             iaddr       [CPUS],
    output logic [CPUS-1:0]   iwait,
    output word_t             iload       [CPUS],
    input  logic [CPUS-1:0]   dREN,
    input  logic [CPUS-1:0]   dWEN,
    input  logic [CPUS-1:0]   ccwrite,
    input  logic [CPUS-1:0]   cctrans,
    input  word_t             daddr       [CPUS],
    input  word_t             dstore      [CPUS],
    output logic [CPUS-1:0]   dwait,
    output word_t             dload       [CPUS],
    output logic [CPUS-1:0]   ccwait,
    output logic [CPUS-1:0]   ccinv,
    output word_t             ccsnoopaddr [CPUS],
    output logic              ramREN,
    output logic              ramWEN,
    output word_t             ramaddr,
    output word_t             ramstore,
    input  word_t             ramload,
    input  ramstate_t         ramstate
);

    localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;

    cc_state_t       state, nstate;
    logic [IW-1:0]   g, g_n, s, s_n;
    logic [IW-1:0]   dptr, dptr_n, iptr, iptr_n;
    logic [CPUS-1:0] dreq, dgnt, igen;
    logic [IW-1:0]   didx, iidx;
    logic            dany, iany, snp_hit;

    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] x);
        return (int'(x) + 1 >= CPUS) ? '0 : IW'(int'(x) + 1);
    endfunction

    assign dreq = dREN | dWEN | cctrans;

    rr_arbiter #(.N(CPUS), .IW(IW)) u_darb (
        .req (dreq),
        .ptr (dptr),
        .gnt (dgnt),
        .idx (didx),
        .any (dany)
    );

    rr_arbiter #(.N(CPUS), .IW(IW)) u_iarb (
        .req (iREN),
        .ptr (iptr),
        .gnt (igen),
        .idx (iidx),
        .any (iany)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            g     <= '0;
            s     <= '0;
            dptr  <= '0;
            iptr  <= '0;
        end else begin
            state <= nstate;
            g     <= g_n;
            s     <= s_n;
            dptr  <= dptr_n;
            iptr  <= iptr_n;
        end
    end

    always_comb begin
        nstate   = state;
        g_n      = g;
        s_n      = s;
        dptr_n   = dptr;
        iptr_n   = iptr;
        snp_hit  = 1'b0;
        iwait    = '1;
        dwait    = '1;
        ccwait   = '0;
        ccinv    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        for (int k = 0; k < CPUS; k++) begin
            iload[k]       = '0;
            dload[k]       = '0;
            ccsnoopaddr[k] = '0;
        end

        case (state)
            IDLE: begin
                if (dany) begin
                    g_n    = didx;
                    nstate = (dWEN[didx] && !cctrans[didx]) ? MEMWR : SNOOP;
                end else if (iany) begin
                    g_n    = iidx;
                    nstate = IFETCH;
                end
            end
            SNOOP: begin
                for (int k = 0; k < CPUS; k++) begin
                    if (k != int'(g)) begin
                        ccwait[k]      = 1'b1;
                        ccsnoopaddr[k] = daddr[g];
                        ccinv[k]       = ccwrite[g];
                        if (!snp_hit && dWEN[k]) begin
                            snp_hit = 1'b1;
                            s_n     = IW'(k);
                        end
                    end
                end
                if (snp_hit) begin
                    nstate = C2C;
                end else if (dREN[g]) begin
                    nstate = MEMRD;
                end else begin
                    // Upgrade only: invalidations went out this cycle, nothing to move.
                    dwait[g] = 1'b0;
                    dptr_n   = nxt(g);
                    nstate   = IDLE;
                end
            end
            MEMRD: begin
                ramREN  = 1'b1;
                ramaddr = daddr[g];
                if (ramstate == ACCESS) begin
                    dload[g] = ramload;
                    dwait[g] = 1'b0;
                    dptr_n   = nxt(g);
                    nstate   = IDLE;
                end
            end
            MEMWR: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[g];
                ramstore = dstore[g];
                if (ramstate == ACCESS) begin
                    dwait[g] = 1'b0;
                    dptr_n   = nxt(g);
                    nstate   = IDLE;
                end
            end
            C2C: begin
                ramWEN    = 1'b1;
                ramaddr   = daddr[s];
                ramstore  = dstore[s];
                dload[g]  = dstore[s];
                ccwait[s] = 1'b1;
                if (ramstate == ACCESS) begin
                    dwait[g] = 1'b0;
                    dwait[s] = 1'b0;
                    dptr_n   = nxt(g);
                    nstate   = IDLE;
                end
            end
            IFETCH: begin
                ramREN  = 1'b1;
                ramaddr = iaddr[g];
                if (ramstate == ACCESS) begin
                    iload[g] = ramload;
                    iwait[g] = 1'b0;
                    iptr_n   = nxt(g);
                    nstate   = IDLE;
                end
            end
            default: nstate = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cc_arbiter.sv
// Directed-step bench for cc_arbiter with CPUS=2 and hand-computed expectations.
module tb_cc_arbiter;
    import cpu_types_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [1:0] iREN, dREN, dWEN, ccwrite, cctrans;
    logic [1:0] iwait, dwait, ccwait, ccinv;
    word_t      iaddr [2];
    word_t      daddr [2];
    word_t      dstore [2];
    word_t      iload [2];
    word_t      dload [2];
    word_t      ccsnoopaddr [2];
    logic       ramREN, ramWEN;
    word_t      ramaddr, ramstore, ramload;
    ramstate_t  ramstate;

    int total = 0;
    int bad   = 0;

    cc_arbiter #(.CPUS(2)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .iREN        (iREN),
        .iaddr       (iaddr),
        .iwait       (iwait),
        .iload       (iload),
        .dREN        (dREN),
        .dWEN        (dWEN),
        .ccwrite     (ccwrite),
        .cctrans     (cctrans),
        .daddr       (daddr),
        .dstore      (dstore),
        .dwait       (dwait),
        .dload       (dload),
        .ccwait      (ccwait),
        .ccinv       (ccinv),
        .ccsnoopaddr (ccsnoopaddr),
        .ramREN      (ramREN),
        .ramWEN      (ramWEN),
        .ramaddr     (ramaddr),
        .ramstore    (ramstore),
        .ramload     (ramload),
        .ramstate    (ramstate)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        iREN = '0; dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
        iaddr[0] = 32'h1000; iaddr[1] = 32'h2000;
        daddr[0] = '0; daddr[1] = '0; dstore[0] = '0; dstore[1] = '0;
        ramload = '0; ramstate = FREE;

        #2;
        chk("rst_iwait", 32'(iwait), 32'h3);
        chk("rst_dwait", 32'(dwait), 32'h3);
        chk("rst_ramren", 32'(ramREN), 32'h0);
        chk("rst_ramwen", 32'(ramWEN), 32'h0);
        chk("rst_ccwait", 32'(ccwait), 32'h0);

        @(posedge CLK); #1;
        RST = 1'b0;
        iREN = 2'b11;

        // Icache round robin: CPU0, CPU1, CPU0
        tick();
        chk("if0_ramren", 32'(ramREN), 32'h1);
        chk("if0_addr", ramaddr, 32'h1000);
        chk("if0_busy_iwait", 32'(iwait), 32'h3);
        ramstate = ACCESS; ramload = 32'hA0; settle();
        chk("if0_iwait", 32'(iwait), 32'h2);
        chk("if0_iload", iload[0], 32'hA0);
        tick();
        ramstate = FREE;
        chk("if_idle_iwait", 32'(iwait), 32'h3);
        chk("if_idle_ramren", 32'(ramREN), 32'h0);
        tick();
        chk("if1_addr", ramaddr, 32'h2000);
        ramstate = ACCESS; ramload = 32'hA1; settle();
        chk("if1_iwait", 32'(iwait), 32'h1);
        chk("if1_iload", iload[1], 32'hA1);
        tick();
        ramstate = FREE;
        tick();
        chk("if2_addr", ramaddr, 32'h1000);
        ramstate = ACCESS; settle();
        chk("if2_iwait", 32'(iwait), 32'h2);
        tick();

        // Dcache read beats simultaneous icache request
        iREN = 2'b10; dREN = 2'b01; daddr[0] = 32'h100; ramstate = FREE;
        tick();
        chk("rd_snp_ccwait", 32'(ccwait), 32'h2);
        chk("rd_snp_addr", ccsnoopaddr[1], 32'h100);
        chk("rd_snp_addr0", ccsnoopaddr[0], 32'h0);
        chk("rd_snp_ccinv", 32'(ccinv), 32'h0);
        chk("rd_snp_strobes", {30'b0, ramREN, ramWEN}, 32'h0);
        tick();
        chk("rd_ramren", 32'(ramREN), 32'h1);
        chk("rd_addr", ramaddr, 32'h100);
        chk("rd_iwait", 32'(iwait), 32'h3);
        ramstate = ACCESS; ramload = 32'h1234; settle();
        chk("rd_dwait", 32'(dwait), 32'h2);
        chk("rd_dload", dload[0], 32'h1234);
        dREN = 2'b00;
        tick();
        ramstate = FREE;
        chk("rd_idle_ramren", 32'(ramREN), 32'h0);
        tick();
        chk("if_after_rd_ramren", 32'(ramREN), 32'h1);
        chk("if_after_rd_addr", ramaddr, 32'h2000);
        ramstate = ACCESS; settle();
        chk("if_after_rd_iwait", 32'(iwait), 32'h1);
        iREN = 2'b00;
        tick();

        // Eviction writeback skips snoop
        ramstate = FREE;
        dWEN = 2'b10; daddr[1] = 32'h40; dstore[1] = 32'hCAFE0001;
        tick();
        chk("ev_ramwen", 32'(ramWEN), 32'h1);
        chk("ev_ramren", 32'(ramREN), 32'h0);
        chk("ev_addr", ramaddr, 32'h40);
        chk("ev_store", ramstore, 32'hCAFE0001);
        chk("ev_ccwait", 32'(ccwait), 32'h0);
        ramstate = ACCESS; settle();
        chk("ev_dwait", 32'(dwait), 32'h1);
        dWEN = 2'b00;
        tick();

        // Cache-to-cache transfer with invalidate
        ramstate = FREE;
        dREN = 2'b01; cctrans = 2'b01; ccwrite = 2'b01; daddr[0] = 32'h200;
        tick();
        chk("c2c_ccinv", 32'(ccinv), 32'h2);
        chk("c2c_snp_ccwait", 32'(ccwait), 32'h2);
        chk("c2c_snp_addr", ccsnoopaddr[1], 32'h200);
        dWEN = 2'b10; dstore[1] = 32'hDEADBEEF; daddr[1] = 32'h200;
        tick();
        chk("c2c_ramwen", 32'(ramWEN), 32'h1);
        chk("c2c_addr", ramaddr, 32'h200);
        chk("c2c_store", ramstore, 32'hDEADBEEF);
        chk("c2c_dload", dload[0], 32'hDEADBEEF);
        chk("c2c_ccwait", 32'(ccwait), 32'h2);
        chk("c2c_busy_dwait", 32'(dwait), 32'h3);
        ramstate = ACCESS; settle();
        chk("c2c_dwait", 32'(dwait), 32'h0);
        dREN = 2'b00; cctrans = 2'b00; ccwrite = 2'b00; dWEN = 2'b00;
        tick();

        // Memory read with ERROR retries
        ramstate = FREE;
        dREN = 2'b01; daddr[0] = 32'h300;
        tick();
        tick();
        ramstate = ERROR; ramload = 32'h55;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("err_ramren", 32'(ramREN), 32'h1);
            chk("err_addr", ramaddr, 32'h300);
            chk("err_dwait", 32'(dwait), 32'h3);
            tick();
        end
        ramstate = ACCESS; settle();
        chk("err_done_dwait", 32'(dwait), 32'h2);
        chk("err_done_dload", dload[0], 32'h55);
        dREN = 2'b00;
        tick();
        chk("err_once_dwait", 32'(dwait), 32'h3);
        chk("err_once_ramren", 32'(ramREN), 32'h0);
        tick();
        chk("err_once2_dwait", 32'(dwait), 32'h3);

        // Reset in the middle of C2C, with dptr pointing at CPU1
        ramstate = FREE;
        dREN = 2'b10; daddr[1] = 32'h500;
        tick();
        chk("rstc2c_snp_ccwait", 32'(ccwait), 32'h1);
        dWEN = 2'b01; dstore[0] = 32'h77; daddr[0] = 32'h500;
        tick();
        chk("rstc2c_ramwen", 32'(ramWEN), 32'h1);
        chk("rstc2c_dload", dload[1], 32'h77);
        #2;
        RST = 1'b1;
        #1;
        chk("rstc2c_iwait", 32'(iwait), 32'h3);
        chk("rstc2c_dwait", 32'(dwait), 32'h3);
        chk("rstc2c_strobes", {30'b0, ramREN, ramWEN}, 32'h0);
        chk("rstc2c_ccwait", 32'(ccwait), 32'h0);
        dWEN = 2'b00; dREN = 2'b11; daddr[0] = 32'h600; daddr[1] = 32'h700;
        tick();
        RST = 1'b0;
        settle();
        chk("post_rst_idle", 32'(ramREN), 32'h0);
        tick();
        chk("post_rst_ccwait", 32'(ccwait), 32'h2);
        chk("post_rst_snpaddr", ccsnoopaddr[1], 32'h600);
        dREN = 2'b00;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
